// File: rtl/cache_pkg.sv
// Shared constants and types for the cache/memory arbiter.
package cache_pkg;

    localparam int unsigned ADDRW     = 26;
    localparam int unsigned LOG2LINEW = 7;
    localparam int unsigned LINEW     = 1 << LOG2LINEW;
    localparam int unsigned LINEBYTES = LINEW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                 read;
        logic [ADDRW-1:0]     paddr;
        logic [LINEW-1:0]     wb_line;
        logic [LINEBYTES-1:0] wb_mask;
    } mem_req_t;

    // Bundle one requester's inputs; byte enables are meaningless on a fill, so clear them.
    function automatic mem_req_t make_req(input logic                 read,
                                          input logic [ADDRW-1:0]     paddr,
                                          input logic [LINEW-1:0]     wb_line,
                                          input logic [LINEBYTES-1:0] wb_mask);
        mem_req_t r;
        r.read    = read;
        r.paddr   = paddr;
        r.wb_line = wb_line;
        r.wb_mask = read ? '0 : wb_mask;
        return r;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Combinational 2-way round-robin picker: on a tie the requester not granted last wins.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       winner
);

    // Pick the winner from the current request vector.
    always_comb begin
        valid  = |req;
        winner = (req == 2'b11) ? ~last_grant : req[1];
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single backing-memory line port between the I-cache (r0) and D-cache (r1).
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 r0_req,
    input  logic                 r1_req,
    input  logic                 r0_read,
    input  logic                 r1_read,
    input  logic [ADDRW-1:0]     r0_paddr,
    input  logic [ADDRW-1:0]     r1_paddr,
    input  logic [LINEW-1:0]     r0_wb_line,
    input  logic [LINEW-1:0]     r1_wb_line,
    input  logic [LINEBYTES-1:0] r0_wb_mask,
    input  logic [LINEBYTES-1:0] r1_wb_mask,
    output logic                 r0_ack,
    output logic                 r1_ack,
    output logic [LINEW-1:0]     fill_line,
    output logic                 mem_req,
    output logic                 mem_read,
    output logic [ADDRW-1:0]     mem_paddr,
    output logic [LINEW-1:0]     mem_wb_line,
    output logic [LINEBYTES-1:0] mem_wb_mask,
    input  logic                 mem_ack,
    input  logic [LINEW-1:0]     mem_fill_line,
    output logic                 grant,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

    arb_state_e      state_q;
    mem_req_t        mem_q;
    mem_req_t        cand;
    logic [CNTW-1:0] cnt_q;
    logic            last_grant_q;
    logic            pick_valid;
    logic            pick_winner;

    arb_rr2 u_pick (
        .req        ({r1_req, r0_req}),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // Request bundle of whichever cache would win this cycle.
    always_comb begin
        cand = pick_winner ? make_req(r1_read, r1_paddr, r1_wb_line, r1_wb_mask)
                           : make_req(r0_read, r0_paddr, r0_wb_line, r0_wb_mask);
    end

    assign mem_read    = mem_q.read;
    assign mem_paddr   = mem_q.paddr;
    assign mem_wb_line = mem_q.wb_line;
    assign mem_wb_mask = mem_q.wb_mask;
    assign busy        = (state_q != IDLE);

    // Arbitration FSM with registered memory request, acks, fill data and watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_q        <= '0;
            mem_req      <= 1'b0;
            r0_ack       <= 1'b0;
            r1_ack       <= 1'b0;
            fill_line    <= '0;
            grant        <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            err          <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        mem_q   <= cand;
                        mem_req <= 1'b1;
                        grant   <= pick_winner;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req      <= 1'b0;
                        r0_ack       <= ~grant;
                        r1_ack       <= grant;
                        last_grant_q <= grant;
                        // Writebacks return no data; keep the last fill visible.
                        if (mem_q.read) begin
                            fill_line <= mem_fill_line;
                        end
                        state_q <= DONE;
                    end else if (cnt_q == CNTW'(TIMEOUT)) begin
                        // Memory hung: complete the transaction with zero data and flag it.
                        err       <= 1'b1;
                        mem_req   <= 1'b0;
                        r0_ack    <= ~grant;
                        r1_ack    <= grant;
                        fill_line <= '0;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                DONE: begin
                    r0_ack  <= 1'b0;
                    r1_ack  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios then randomized transactions.
module tb_cache_mem_arbiter;
    import cache_pkg::*;

    localparam int unsigned TO = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 r0_req, r1_req, r0_read, r1_read;
    logic [ADDRW-1:0]     r0_paddr, r1_paddr;
    logic [LINEW-1:0]     r0_wb_line, r1_wb_line;
    logic [LINEBYTES-1:0] r0_wb_mask, r1_wb_mask;
    logic                 r0_ack, r1_ack;
    logic [LINEW-1:0]     fill_line;
    logic                 mem_req, mem_read;
    logic [ADDRW-1:0]     mem_paddr;
    logic [LINEW-1:0]     mem_wb_line;
    logic [LINEBYTES-1:0] mem_wb_mask;
    logic                 mem_ack;
    logic [LINEW-1:0]     mem_fill_line;
    logic                 grant, busy, err;

    int checks = 0;
    int errors = 0;

    // Reference model state: who completed last, what fill is visible, sticky error.
    logic             m_last;
    logic [LINEW-1:0] m_fill;
    logic             m_err;

    cache_mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .r0_req        (r0_req),
        .r1_req        (r1_req),
        .r0_read       (r0_read),
        .r1_read       (r1_read),
        .r0_paddr      (r0_paddr),
        .r1_paddr      (r1_paddr),
        .r0_wb_line    (r0_wb_line),
        .r1_wb_line    (r1_wb_line),
        .r0_wb_mask    (r0_wb_mask),
        .r1_wb_mask    (r1_wb_mask),
        .r0_ack        (r0_ack),
        .r1_ack        (r1_ack),
        .fill_line     (fill_line),
        .mem_req       (mem_req),
        .mem_read      (mem_read),
        .mem_paddr     (mem_paddr),
        .mem_wb_line   (mem_wb_line),
        .mem_wb_mask   (mem_wb_mask),
        .mem_ack       (mem_ack),
        .mem_fill_line (mem_fill_line),
        .grant         (grant),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINEW-1:0] obs, input logic [LINEW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINEW-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Tie goes to the requester that did not complete last; otherwise the lone requester.
    function automatic logic pick(input logic a0, input logic a1, input logic last);
        if (a0 && a1) return ~last;
        return a1;
    endfunction

    // One full transaction from the grant edge through the ack edge (DUT ends in its ack cycle).
    task automatic serve(input int d, input logic [LINEW-1:0] fill, input bit scramble);
        logic                 w;
        logic                 e_read;
        logic [ADDRW-1:0]     e_paddr;
        logic [LINEW-1:0]     e_line;
        logic [LINEBYTES-1:0] e_mask;
        w       = pick(r0_req, r1_req, m_last);
        e_read  = w ? r1_read : r0_read;
        e_paddr = w ? r1_paddr : r0_paddr;
        e_line  = w ? r1_wb_line : r0_wb_line;
        e_mask  = e_read ? '0 : (w ? r1_wb_mask : r0_wb_mask);
        @(posedge clk); #1;
        chk("grant_mem_req", mem_req, 1);
        chk("grant_idx", grant, w);
        chk("grant_busy", busy, 1);
        chk("grant_read", mem_read, e_read);
        chk("grant_paddr", mem_paddr, e_paddr);
        chk("grant_line", mem_wb_line, e_line);
        chk("grant_mask", mem_wb_mask, e_mask);
        for (int i = 1; i < d; i++) begin
            if (scramble) begin
                r0_req = 1'($urandom); r1_req = 1'($urandom);
                r0_read = 1'($urandom); r1_read = 1'($urandom);
                r0_paddr = ADDRW'($urandom); r1_paddr = ADDRW'($urandom);
                r0_wb_line = rnd_line(); r1_wb_line = rnd_line();
            end
            @(posedge clk); #1;
            chk("busy_mem_req", mem_req, 1);
            chk("busy_paddr", mem_paddr, e_paddr);
            chk("busy_line", mem_wb_line, e_line);
            chk("busy_no_ack", {r1_ack, r0_ack}, 0);
        end
        mem_ack = 1'b1;
        mem_fill_line = fill;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        mem_fill_line = rnd_line();
        if (e_read) m_fill = fill;
        m_last = w;
        chk("ack_r0", r0_ack, !w);
        chk("ack_r1", r1_ack, w);
        chk("ack_fill", fill_line, m_fill);
        chk("ack_mem_req", mem_req, 0);
        chk("ack_err", err, m_err);
    endtask

    // Ack cycle -> IDLE.
    task automatic done_step();
        @(posedge clk); #1;
        chk("done_acks", {r1_ack, r0_ack}, 0);
        chk("done_busy", busy, 0);
        chk("done_mem_req", mem_req, 0);
        chk("done_fill", fill_line, m_fill);
    endtask

    initial begin
        rst_n = 1'b0;
        {r0_req, r1_req, r0_read, r1_read, mem_ack} = '0;
        r0_paddr = '0; r1_paddr = '0;
        r0_wb_line = '0; r1_wb_line = '0;
        r0_wb_mask = '0; r1_wb_mask = '0;
        mem_fill_line = '0;
        m_last = 1'b1; m_fill = '0; m_err = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {mem_req, mem_read, r0_ack, r1_ack, busy, err, grant}, 0);
        chk("rst_fill", fill_line, 0);
        chk("rst_mem_fields", {mem_paddr, mem_wb_mask}, 0);
        rst_n = 1'b1;

        // r0 read, ack two cycles after mem_req.
        r0_req = 1'b1; r0_read = 1'b1; r0_paddr = 26'h0001230;
        r0_wb_mask = 16'hBEEF;
        serve(2, {4{32'hDEADBEEF}}, 0);
        r0_req = 1'b0;
        done_step();

        // Both held: grants alternate.
        r0_req = 1'b1; r1_req = 1'b1; r1_read = 1'b1; r1_paddr = 26'h0000440;
        for (int k = 0; k < 4; k++) begin
            serve(1 + k, rnd_line(), 0);
            done_step();
        end
        r0_req = 1'b0; r1_req = 1'b0;

        // r1 writeback, then holds req and switches to a read during the ack cycle.
        r1_req = 1'b1; r1_read = 1'b0; r1_paddr = 26'h0002000;
        r1_wb_mask = 16'hFFFF; r1_wb_line = {16{8'hA5}};
        serve(3, rnd_line(), 0);
        r1_read = 1'b1; r1_paddr = 26'h0003000;
        done_step();
        serve(1, {4{32'h0BADF00D}}, 0);
        r1_req = 1'b0;
        done_step();

        // Watchdog: memory never answers.
        r0_req = 1'b1; r0_read = 1'b1; r0_paddr = 26'h0000100;
        @(posedge clk); #1;
        r0_req = 1'b0;
        chk("to_mem_req", mem_req, 1);
        for (int i = 0; i < int'(TO); i++) begin
            @(posedge clk); #1;
            chk("to_wait", {r1_ack, r0_ack, err, mem_req}, 4'b0001);
        end
        @(posedge clk); #1;
        m_fill = '0; m_err = 1'b1;
        chk("to_fire", {r1_ack, r0_ack, err, mem_req}, 4'b0110);
        chk("to_fill", fill_line, 0);
        done_step();
        r1_req = 1'b1; r1_read = 1'b0; r1_wb_mask = 16'h00F0;
        serve(2, rnd_line(), 0);
        r1_req = 1'b0;
        done_step();
        chk("err_sticky", err, 1);

        // Reset in BUSY abandons the transaction; r0 then wins a tie.
        r0_req = 1'b1; r1_req = 1'b1;
        @(posedge clk); #1;
        chk("rb_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rb_async", {mem_req, r0_ack, r1_ack, busy, err, grant}, 0);
        chk("rb_fill", fill_line, 0);
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("rb_no_ack", {r0_ack, r1_ack, busy}, 0);
        m_last = 1'b1; m_fill = '0; m_err = 1'b0;
        rst_n = 1'b1;
        serve(2, rnd_line(), 0);
        chk("rb_r0_wins", r0_ack, 1);
        r0_req = 1'b0; r1_req = 1'b0;
        done_step();

        // Randomized transactions with idle noise and input churn while busy.
        for (int n = 0; n < 40; n++) begin
            int idle_cycles;
            idle_cycles = $urandom_range(0, 2);
            for (int i = 0; i < idle_cycles; i++) begin
                mem_ack = 1'($urandom);
                @(posedge clk); #1;
                chk("idle_quiet", {busy, mem_req, r0_ack, r1_ack}, 0);
            end
            mem_ack = 1'b0;
            do begin
                r0_req = 1'($urandom); r1_req = 1'($urandom);
            end while (!(r0_req || r1_req));
            r0_read = 1'($urandom); r1_read = 1'($urandom);
            r0_paddr = ADDRW'($urandom) & ~ADDRW'(LINEBYTES - 1);
            r1_paddr = ADDRW'($urandom) & ~ADDRW'(LINEBYTES - 1);
            r0_wb_line = rnd_line(); r1_wb_line = rnd_line();
            r0_wb_mask = LINEBYTES'($urandom); r1_wb_mask = LINEBYTES'($urandom);
            serve($urandom_range(1, 6), rnd_line(), 1);
            r0_req = 1'b0; r1_req = 1'b0;
            mem_ack = 1'($urandom);
            done_step();
            mem_ack = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
